// File: rtl/yari_mem_arbiter.sv
// rtl/yari_mem_arbiter.sv - D$/I$ arbiter for the shared external memory port of the yari core
module yari_mem_arbiter #(
  parameter int ID_DC           = 1,
  parameter int ID_IC           = 2,
  parameter int STARVE_LIMIT    = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clock,
  input  logic        rst,

  input  logic [29:0] dmem_address,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic [31:0] dmem_writedata,
  input  logic [3:0]  dmem_writedatamask,
  output logic        dmem_waitrequest,
  output logic [31:0] dmem_readdata,
  output logic        dmem_readdatavalid,

  input  logic [29:0] imem_address,
  input  logic        imem_read,
  output logic        imem_waitrequest,
  output logic [31:0] imem_readdata,
  output logic        imem_readdatavalid,

  input  logic        mem_waitrequest,
  output logic [1:0]  mem_id,
  output logic [29:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_writedatamask,
  input  logic [31:0] mem_readdata,
  input  logic [1:0]  mem_readdataid,

  output logic        err_spurious
);

  localparam int              SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [1:0]      TAG_DC     = 2'(ID_DC);
  localparam logic [1:0]      TAG_IC     = 2'(ID_IC);
  localparam logic [2:0]      OUT_MAX    = 3'(MAX_OUTSTANDING);
  localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);

  // Bus ownership: open for arbitration, or locked to the requester whose
  // request is stalled on the bus and must stay there until accepted.
  typedef enum logic [1:0] {
    ST_OPEN   = 2'd0,
    ST_LOCK_D = 2'd1,
    ST_LOCK_I = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [SW-1:0]   starve_cnt;
  logic [2:0]      d_out;
  logic [2:0]      i_out;

  logic            d_elig;
  logic            i_elig;
  logic            starved;
  logic            sel_d;
  logic            sel_i;
  logic            strobe;
  logic            accept;
  logic            d_rd_acc;
  logic            i_rd_acc;
  logic            d_ret;
  logic            i_ret;
  logic            spurious;

  assign d_elig  = (dmem_read && (d_out < OUT_MAX)) || dmem_write;
  assign i_elig  = imem_read && (i_out < OUT_MAX);
  assign starved = (starve_cnt == STARVE_MAX);

  // Pick who drives the bus this cycle: lock owner first, then a starved or
  // uncontested I$, otherwise D$ which has priority.
  always_comb begin
    sel_d = 1'b0;
    sel_i = 1'b0;
    case (state)
      ST_LOCK_D: sel_d = 1'b1;
      ST_LOCK_I: sel_i = 1'b1;
      default: begin
        if (i_elig && (!d_elig || starved)) begin
          sel_i = 1'b1;
        end else if (d_elig) begin
          sel_d = 1'b1;
        end
      end
    endcase
  end

  // Drive the memory bus and requester handshakes from the selection; reset
  // blocks every strobe so nothing leaks out while the core is held.
  always_comb begin
    mem_read          = !rst && ((sel_d && dmem_read) || (sel_i && imem_read));
    mem_write         = !rst && sel_d && dmem_write;
    mem_address       = sel_i ? imem_address : dmem_address;
    mem_id            = sel_i ? TAG_IC : TAG_DC;
    mem_writedata     = dmem_writedata;
    mem_writedatamask = dmem_writedatamask;
    dmem_waitrequest  = rst || !sel_d || mem_waitrequest;
    imem_waitrequest  = rst || !sel_i || mem_waitrequest;
  end

  assign strobe   = mem_read || mem_write;
  assign accept   = strobe && !mem_waitrequest;
  assign d_rd_acc = accept && sel_d && dmem_read;
  assign i_rd_acc = accept && sel_i && imem_read;

  // A return only counts for a requester that actually has a read in flight;
  // anything else on a non-zero tag is an orphan.
  assign d_ret    = (mem_readdataid == TAG_DC) && (d_out != 3'd0);
  assign i_ret    = (mem_readdataid == TAG_IC) && (i_out != 3'd0);
  assign spurious = (mem_readdataid != 2'd0) && !d_ret && !i_ret;

  // Return data goes straight through; only the valid strobes are steered.
  always_comb begin
    dmem_readdata      = mem_readdata;
    imem_readdata      = mem_readdata;
    dmem_readdatavalid = d_ret;
    imem_readdatavalid = i_ret;
  end

  // Ownership state register.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state <= ST_OPEN;
    end else begin
      state <= state_next;
    end
  end

  // Lock on a stalled strobe, release on any accept.
  always_comb begin
    state_next = state;
    if (accept) begin
      state_next = ST_OPEN;
    end else if (strobe) begin
      state_next = sel_i ? ST_LOCK_I : ST_LOCK_D;
    end
  end

  // Count cycles an I$ read waits; a full count forces the next I$ grant.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!imem_read || i_rd_acc) begin
      starve_cnt <= '0;
    end else if (!starved) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Reads in flight for D$; an accept and a return in one cycle cancel.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      d_out <= 3'd0;
    end else begin
      case ({d_rd_acc, d_ret})
        2'b10:   d_out <= d_out + 3'd1;
        2'b01:   d_out <= d_out - 3'd1;
        default: d_out <= d_out;
      endcase
    end
  end

  // Reads in flight for I$; same rules as the D$ counter.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      i_out <= 3'd0;
    end else begin
      case ({i_rd_acc, i_ret})
        2'b10:   i_out <= i_out + 3'd1;
        2'b01:   i_out <= i_out - 3'd1;
        default: i_out <= i_out;
      endcase
    end
  end

  // Sticky flag for returns nobody was waiting for, including late returns
  // that arrive after a reset wiped the counters.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      err_spurious <= 1'b0;
    end else if (spurious) begin
      err_spurious <= 1'b1;
    end
  end

endmodule
